// File: rtl/raccoon_game_pkg.sv
// Shared constants for the raccoon crossing game core: state encoding,
// coordinate widths, and a helper that clamps frame-count parameters.
package raccoon_game_pkg;

    localparam int COORD_W = 10;
    localparam int WIDE_W  = 11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUNNING   = 3'd1;
    localparam logic [2:0] ST_INVULN    = 3'd2;
    localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    // A frame count of zero still has to hold the state for one frame.
    function automatic int frames_at_least_one(input int frames);
        return (frames < 1) ? 1 : frames;
    endfunction

endpackage

// File: rtl/raccoon_aabb_hit.sv
// Axis-aligned box overlap test between the player and one car lane.
// Coordinates are widened by one bit before adding box sizes so that
// boxes near the right/bottom screen edge do not wrap around.
module raccoon_aabb_hit
    import raccoon_game_pkg::*;
#(
    parameter int C_PLAYER_W = 32,
    parameter int C_PLAYER_H = 32,
    parameter int C_CAR_W    = 64,
    parameter int C_CAR_H    = 32
) (
    input  logic [COORD_W-1:0] i_Player_X,
    input  logic [COORD_W-1:0] i_Player_Y,
    input  logic [COORD_W-1:0] i_Car_X,
    input  logic [COORD_W-1:0] i_Car_Y,
    input  logic               i_En,
    output logic               o_Hit
);

    logic [WIDE_W-1:0] w_Px;
    logic [WIDE_W-1:0] w_Py;
    logic [WIDE_W-1:0] w_Cx;
    logic [WIDE_W-1:0] w_Cy;
    logic [WIDE_W-1:0] w_Px_End;
    logic [WIDE_W-1:0] w_Py_End;
    logic [WIDE_W-1:0] w_Cx_End;
    logic [WIDE_W-1:0] w_Cy_End;

    assign w_Px     = {1'b0, i_Player_X};
    assign w_Py     = {1'b0, i_Player_Y};
    assign w_Cx     = {1'b0, i_Car_X};
    assign w_Cy     = {1'b0, i_Car_Y};
    assign w_Px_End = w_Px + WIDE_W'(C_PLAYER_W);
    assign w_Py_End = w_Py + WIDE_W'(C_PLAYER_H);
    assign w_Cx_End = w_Cx + WIDE_W'(C_CAR_W);
    assign w_Cy_End = w_Cy + WIDE_W'(C_CAR_H);

    // Boxes overlap when they overlap on both axes; a disabled lane never hits.
    assign o_Hit = i_En
                 && (w_Px < w_Cx_End) && (w_Px_End > w_Cx)
                 && (w_Py < w_Cy_End) && (w_Py_End > w_Cy);

endmodule

// File: rtl/raccoon_game_fsm.sv
// Game-state core for the raccoon crossing game. Detects player/car
// collisions, tracks lives, score and level, and sequences the
// invulnerability, level-up pause and game-over screens on frame ticks.
module raccoon_game_fsm
    import raccoon_game_pkg::*;
#(
    parameter int C_CAR_COUNT     = 3,
    parameter int C_LIFE          = 3,
    parameter int C_PLAYER_W      = 32,
    parameter int C_PLAYER_H      = 32,
    parameter int C_CAR_W         = 64,
    parameter int C_CAR_H         = 32,
    parameter int C_GOAL_ROW      = 0,
    parameter int C_INVULN_FRAMES = 120,
    parameter int C_BLINK_LOG2    = 3,
    parameter int C_LEVEL_PAUSE   = 60,
    parameter int C_OVER_FRAMES   = 180,
    parameter int C_MAX_LEVEL     = 15
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_Frame_Tick,
    input  logic                           i_Game_Start,
    input  logic [COORD_W-1:0]             i_Player_X,
    input  logic [COORD_W-1:0]             i_Player_Y,
    input  logic [COORD_W*C_CAR_COUNT-1:0] i_Car_X,
    input  logic [COORD_W*C_CAR_COUNT-1:0] i_Car_Y,
    input  logic [C_CAR_COUNT-1:0]         i_Car_En,
    output logic [2:0]                     o_State,
    output logic                           o_Game_Active,
    output logic [3:0]                     o_Life,
    output logic [7:0]                     o_Score,
    output logic [3:0]                     o_Level,
    output logic                           o_Hit,
    output logic                           o_Player_Reset,
    output logic                           o_Player_Visible
);

    localparam int LOAD_INVULN = frames_at_least_one(C_INVULN_FRAMES);
    localparam int LOAD_PAUSE  = frames_at_least_one(C_LEVEL_PAUSE);
    localparam int LOAD_OVER   = frames_at_least_one(C_OVER_FRAMES);
    localparam int LOAD_MAX_A  = (LOAD_INVULN > LOAD_PAUSE) ? LOAD_INVULN : LOAD_PAUSE;
    localparam int LOAD_MAX    = (LOAD_MAX_A > LOAD_OVER) ? LOAD_MAX_A : LOAD_OVER;
    localparam int TMR_W_RAW   = $clog2(LOAD_MAX + 1);
    localparam int TMR_W       = (TMR_W_RAW > C_BLINK_LOG2) ? TMR_W_RAW : C_BLINK_LOG2 + 1;

    localparam logic [TMR_W-1:0] T_INVULN = TMR_W'(LOAD_INVULN);
    localparam logic [TMR_W-1:0] T_PAUSE  = TMR_W'(LOAD_PAUSE);
    localparam logic [TMR_W-1:0] T_OVER   = TMR_W'(LOAD_OVER);
    localparam logic [3:0]       LIFE_INIT = 4'(C_LIFE);
    localparam logic [3:0]       LEVEL_MAX = 4'(C_MAX_LEVEL);

    logic [C_CAR_COUNT-1:0] w_Lane_Hit;
    logic                   w_Win;
    logic                   w_Tmr_Last;
    logic                   r_Coll;
    logic [2:0]             r_State;
    logic [TMR_W-1:0]       r_Timer;
    logic [3:0]             r_Life;
    logic [7:0]             r_Score;
    logic [3:0]             r_Level;
    logic                   r_Hit;
    logic                   r_Player_Reset;

    genvar k;
    generate
        for (k = 0; k < C_CAR_COUNT; k++) begin : g_lane
            raccoon_aabb_hit #(
                .C_PLAYER_W (C_PLAYER_W),
                .C_PLAYER_H (C_PLAYER_H),
                .C_CAR_W    (C_CAR_W),
                .C_CAR_H    (C_CAR_H)
            ) u_hit (
                .i_Player_X (i_Player_X),
                .i_Player_Y (i_Player_Y),
                .i_Car_X    (i_Car_X[COORD_W*k +: COORD_W]),
                .i_Car_Y    (i_Car_Y[COORD_W*k +: COORD_W]),
                .i_En       (i_Car_En[k]),
                .o_Hit      (w_Lane_Hit[k])
            );
        end
    endgenerate

    assign w_Win      = (i_Player_Y <= COORD_W'(C_GOAL_ROW));
    assign w_Tmr_Last = (r_Timer <= TMR_W'(1));

    // Register the ORed lane hits so the FSM sees a clean one-cycle-late collision.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Coll <= 1'b0;
        end else begin
            r_Coll <= |w_Lane_Hit;
        end
    end

    // Main game FSM: state, timers, lives/score/level and one-cycle pulses.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State        <= ST_IDLE;
            r_Timer        <= '0;
            r_Life         <= LIFE_INIT;
            r_Score        <= 8'd0;
            r_Level        <= 4'd0;
            r_Hit          <= 1'b0;
            r_Player_Reset <= 1'b0;
        end else begin
            r_Hit          <= 1'b0;
            r_Player_Reset <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (i_Game_Start) begin
                        r_State        <= ST_RUNNING;
                        r_Timer        <= '0;
                        r_Life         <= LIFE_INIT;
                        r_Score        <= 8'd0;
                        r_Level        <= 4'd0;
                        r_Player_Reset <= 1'b1;
                    end
                end
                ST_RUNNING, ST_INVULN: begin
                    if (w_Win) begin
                        r_State        <= ST_LEVEL_UP;
                        r_Timer        <= T_PAUSE;
                        r_Player_Reset <= 1'b1;
                        if (r_Score != 8'hFF) begin
                            r_Score <= r_Score + 8'd1;
                        end
                        if (r_Level < LEVEL_MAX) begin
                            r_Level <= r_Level + 4'd1;
                        end
                    end else if ((r_State == ST_RUNNING) && r_Coll) begin
                        r_Hit <= 1'b1;
                        if (r_Life > 4'd1) begin
                            r_Life         <= r_Life - 4'd1;
                            r_State        <= ST_INVULN;
                            r_Timer        <= T_INVULN;
                            r_Player_Reset <= 1'b1;
                        end else begin
                            r_Life  <= 4'd0;
                            r_State <= ST_GAME_OVER;
                            r_Timer <= T_OVER;
                        end
                    end else if ((r_State == ST_INVULN) && i_Frame_Tick) begin
                        if (w_Tmr_Last) begin
                            r_State <= ST_RUNNING;
                            r_Timer <= '0;
                        end else begin
                            r_Timer <= r_Timer - TMR_W'(1);
                        end
                    end
                end
                ST_LEVEL_UP: begin
                    if (i_Frame_Tick) begin
                        if (w_Tmr_Last) begin
                            r_State <= ST_RUNNING;
                            r_Timer <= '0;
                        end else begin
                            r_Timer <= r_Timer - TMR_W'(1);
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (i_Frame_Tick) begin
                        if (w_Tmr_Last) begin
                            r_State <= ST_IDLE;
                            r_Timer <= '0;
                        end else begin
                            r_Timer <= r_Timer - TMR_W'(1);
                        end
                    end
                end
                default: begin
                    r_State <= ST_IDLE;
                    r_Timer <= '0;
                end
            endcase
        end
    end

    assign o_State          = r_State;
    assign o_Game_Active    = (r_State == ST_RUNNING) || (r_State == ST_INVULN);
    assign o_Life           = r_Life;
    assign o_Score          = r_Score;
    assign o_Level          = r_Level;
    assign o_Hit            = r_Hit;
    assign o_Player_Reset   = r_Player_Reset;
    assign o_Player_Visible = (r_State == ST_INVULN) ? ~r_Timer[C_BLINK_LOG2] : 1'b1;

endmodule

// File: tb/tb_raccoon_game_fsm.sv
// Testbench for raccoon_game_fsm: expected snapshots are queued when a
// pulse-producing stimulus is issued and popped by a monitor whenever
// o_Hit or o_Player_Reset appears; level checks cover timers and blink.
module tb_raccoon_game_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] life;
        logic [7:0] score;
        logic [3:0] level;
        logic       hit;
        logic       pr;
    } snap_t;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_Frame_Tick;
    logic        i_Game_Start;
    logic [9:0]  i_Player_X;
    logic [9:0]  i_Player_Y;
    logic [29:0] i_Car_X;
    logic [29:0] i_Car_Y;
    logic [2:0]  i_Car_En;
    logic [2:0]  o_State;
    logic        o_Game_Active;
    logic [3:0]  o_Life;
    logic [7:0]  o_Score;
    logic [3:0]  o_Level;
    logic        o_Hit;
    logic        o_Player_Reset;
    logic        o_Player_Visible;

    int    checkCount = 0;
    int    failCount  = 0;
    int    pulseCount = 0;
    snap_t expQ[$];

    raccoon_game_fsm #(
        .C_CAR_COUNT (3),
        .C_LIFE      (3)
    ) dut (
        .i_Clk            (i_Clk),
        .i_Rst            (i_Rst),
        .i_Frame_Tick     (i_Frame_Tick),
        .i_Game_Start     (i_Game_Start),
        .i_Player_X       (i_Player_X),
        .i_Player_Y       (i_Player_Y),
        .i_Car_X          (i_Car_X),
        .i_Car_Y          (i_Car_Y),
        .i_Car_En         (i_Car_En),
        .o_State          (o_State),
        .o_Game_Active    (o_Game_Active),
        .o_Life           (o_Life),
        .o_Score          (o_Score),
        .o_Level          (o_Level),
        .o_Hit            (o_Hit),
        .o_Player_Reset   (o_Player_Reset),
        .o_Player_Visible (o_Player_Visible)
    );

    // 10 ns clock.
    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    // Monitor: every pulse cycle must match the next queued snapshot.
    always @(negedge i_Clk) begin
        if (!i_Rst && (o_Hit || o_Player_Reset)) begin
            snap_t got;
            snap_t exp;
            got = '{o_State, o_Life, o_Score, o_Level, o_Hit, o_Player_Reset};
            pulseCount++;
            checkCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL pulse%0d unexpected: got st=%0d life=%0d score=%0d lvl=%0d hit=%0d pr=%0d, required no pulse",
                         pulseCount, got.st, got.life, got.score, got.level, got.hit, got.pr);
            end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                    failCount++;
                    $display("[TB] FAIL pulse%0d: got st=%0d life=%0d score=%0d lvl=%0d hit=%0d pr=%0d, required st=%0d life=%0d score=%0d lvl=%0d hit=%0d pr=%0d",
                             pulseCount, got.st, got.life, got.score, got.level, got.hit, got.pr,
                             exp.st, exp.life, exp.score, exp.level, exp.hit, exp.pr);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int px, input int py, input int lane,
                                 input int cx, input int cy);
        i_Player_X = 10'(px);
        i_Player_Y = 10'(py);
        i_Car_X[10*lane +: 10] = 10'(cx);
        i_Car_Y[10*lane +: 10] = 10'(cy);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic doTicks(input int n);
        repeat (n) begin
            @(negedge i_Clk);
            i_Frame_Tick = 1'b1;
            @(negedge i_Clk);
            i_Frame_Tick = 1'b0;
        end
    endtask

    task automatic pulseStart();
        @(negedge i_Clk);
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        i_Game_Start = 1'b0;
    endtask

    initial begin
        i_Rst        = 1'b1;
        i_Frame_Tick = 1'b0;
        i_Game_Start = 1'b0;
        i_Car_En     = 3'b111;
        i_Car_X      = '0;
        i_Car_Y      = '0;
        applyStimulus(300, 300, 0, 600, 400);
        applyStimulus(300, 300, 1, 700, 400);
        applyStimulus(300, 300, 2, 800, 450);
        waitCycles(3);

        checkOutput("rst_state", o_State, 0);
        checkOutput("rst_life", o_Life, 3);
        checkOutput("rst_score", o_Score, 0);
        checkOutput("rst_level", o_Level, 0);
        checkOutput("rst_hit", o_Hit, 0);
        checkOutput("rst_preset", o_Player_Reset, 0);
        checkOutput("rst_visible", o_Player_Visible, 1);
        checkOutput("rst_active", o_Game_Active, 0);
        i_Rst = 1'b0;
        waitCycles(2);

        // Start game.
        expQ.push_back('{3'd1, 4'd3, 8'd0, 4'd0, 1'b0, 1'b1});
        pulseStart();
        waitCycles(2);
        checkOutput("start_state", o_State, 1);
        checkOutput("start_active", o_Game_Active, 1);

        // First hit, overlap held through invulnerability.
        expQ.push_back('{3'd2, 4'd2, 8'd0, 4'd0, 1'b1, 1'b1});
        applyStimulus(100, 200, 0, 80, 210);
        waitCycles(3);
        checkOutput("hit1_state", o_State, 2);
        checkOutput("hit1_visible_t120", o_Player_Visible, 0);
        doTicks(8);
        checkOutput("blink_t112", o_Player_Visible, 1);
        doTicks(8);
        checkOutput("blink_t104", o_Player_Visible, 0);
        doTicks(103);
        checkOutput("invuln_t1_state", o_State, 2);
        applyStimulus(100, 200, 0, 600, 400);
        waitCycles(2);
        doTicks(1);
        checkOutput("invuln_end_state", o_State, 1);
        checkOutput("invuln_end_life", o_Life, 2);

        // Win with a collision reported in the same cycle: win takes priority.
        expQ.push_back('{3'd3, 4'd2, 8'd1, 4'd1, 1'b0, 1'b1});
        applyStimulus(100, 20, 0, 80, 30);
        @(negedge i_Clk);
        applyStimulus(100, 0, 0, 80, 10);
        waitCycles(2);
        checkOutput("win_state", o_State, 3);
        checkOutput("win_life", o_Life, 2);
        checkOutput("win_active", o_Game_Active, 0);
        applyStimulus(300, 300, 0, 600, 400);
        doTicks(59);
        checkOutput("pause_t1_state", o_State, 3);
        doTicks(1);
        checkOutput("pause_end_state", o_State, 1);
        checkOutput("pause_end_level", o_Level, 1);

        // Second hit, then final hit on lane 2 into game over.
        expQ.push_back('{3'd2, 4'd1, 8'd1, 4'd1, 1'b1, 1'b1});
        applyStimulus(100, 200, 0, 80, 210);
        waitCycles(3);
        checkOutput("hit2_state", o_State, 2);
        checkOutput("hit2_life", o_Life, 1);
        applyStimulus(100, 200, 0, 600, 400);
        waitCycles(2);
        doTicks(120);
        checkOutput("hit2_end_state", o_State, 1);
        expQ.push_back('{3'd4, 4'd0, 8'd1, 4'd1, 1'b1, 1'b0});
        applyStimulus(100, 200, 2, 80, 210);
        waitCycles(3);
        checkOutput("over_state", o_State, 4);
        checkOutput("over_life", o_Life, 0);
        checkOutput("over_active", o_Game_Active, 0);
        applyStimulus(300, 300, 2, 800, 450);
        doTicks(179);
        checkOutput("over_t1_state", o_State, 4);
        doTicks(1);
        checkOutput("idle_state", o_State, 0);
        checkOutput("idle_score_kept", o_Score, 1);
        checkOutput("idle_level_kept", o_Level, 1);

        // Restart and drive score/level into saturation.
        expQ.push_back('{3'd1, 4'd3, 8'd0, 4'd0, 1'b0, 1'b1});
        pulseStart();
        waitCycles(2);
        for (int w = 1; w <= 256; w++) begin
            expQ.push_back('{3'd3, 4'd3, 8'((w > 255) ? 255 : w), 4'((w > 15) ? 15 : w), 1'b0, 1'b1});
            i_Player_Y = 10'd0;
            @(negedge i_Clk);
            i_Player_Y = 10'd300;
            doTicks(60);
        end
        checkOutput("sat_score", o_Score, 255);
        checkOutput("sat_level", o_Level, 15);
        checkOutput("sat_state", o_State, 1);

        // Disabled lane never collides; then reset in the middle of invulnerability.
        i_Car_En = 3'b110;
        applyStimulus(100, 200, 0, 80, 210);
        waitCycles(5);
        checkOutput("dis_state", o_State, 1);
        checkOutput("dis_life", o_Life, 3);
        expQ.push_back('{3'd2, 4'd2, 8'd255, 4'd15, 1'b1, 1'b1});
        i_Car_En = 3'b111;
        waitCycles(3);
        checkOutput("en_state", o_State, 2);
        checkOutput("en_visible", o_Player_Visible, 0);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        checkOutput("midrst_state", o_State, 0);
        checkOutput("midrst_life", o_Life, 3);
        checkOutput("midrst_visible", o_Player_Visible, 1);
        checkOutput("midrst_score", o_Score, 0);
        checkOutput("midrst_level", o_Level, 0);
        i_Rst = 1'b0;
        applyStimulus(300, 300, 0, 600, 400);
        waitCycles(3);

        checkOutput("queue_left", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
